// File: rtl/alu_op_sequencer.sv
// Issues requests to an external combinational ALU, applies ARM condition codes and keeps NZCV flags.
// Latency: a response is valid 2 edges after request accept; the minimum issue interval is 3 cycles.
// Backpressure: one op in flight; req_ready is low until the response is taken with rsp_ready.
//
// Ports:
//   clk, rst_n                   clock and async active-low reset
//   req_valid/req_ready          request handshake: req_op, req_a, req_b, req_cond, req_setf
//   alu_a, alu_b, alu_ctrl       registered operands and control code for the external ALU
//   alu_out, alu_n/z/co/ovf      ALU result and flags, sampled in EXEC
//   rsp_valid/rsp_ready          response handshake: rsp_data, rsp_exec
//   flags_nzcv                   architectural flag register {N,Z,C,V}
module alu_op_sequencer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W:0]   req_a,
  input  logic [W:0]   req_b,
  input  logic [3:0]   req_cond,
  input  logic         req_setf,
  output logic [W:0]   alu_a,
  output logic [W:0]   alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W:0]   alu_out,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_co,
  input  logic         alu_ovf,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W:0]   rsp_data,
  output logic         rsp_exec,
  output logic [3:0]   flags_nzcv
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cond_q;
  logic       setf_q;
  logic       cond_pass;
  logic       f_n, f_z, f_c, f_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  // Condition is checked against the flags before the current op commits,
  // so a flag write by op k is seen by op k+1.
  assign {f_n, f_z, f_c, f_v} = flags_nzcv;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = !f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = !f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = !f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = !f_v;
      4'b1000: cond_pass = f_c && !f_z;
      4'b1001: cond_pass = !f_c || f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = !f_z && (f_n == f_v);
      4'b1101: cond_pass = f_z || (f_n != f_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 3'b000;
      cond_q     <= 4'b0000;
      setf_q     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_exec   <= 1'b0;
      flags_nzcv <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_ctrl <= req_op;
            cond_q   <= req_cond;
            setf_q   <= req_setf;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          if (cond_pass) begin
            rsp_data <= alu_out;
            rsp_exec <= 1'b1;
            if (setf_q) flags_nzcv <= {alu_n, alu_z, alu_co, alu_ovf};
          end else begin
            rsp_data <= '0;
            rsp_exec <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU attached to its ALU ports.
// Latency: checks response timing at exactly 2 edges after accept.
// Backpressure: exercises rsp_ready held low while a new request is pulsed.
module tb_alu_op_sequencer;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W:0]   req_a;
  logic [W:0]   req_b;
  logic [3:0]   req_cond;
  logic         req_setf;
  logic [W:0]   alu_a;
  logic [W:0]   alu_b;
  logic [2:0]   alu_ctrl;
  logic [W:0]   alu_out;
  logic         alu_n, alu_z, alu_co, alu_ovf;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W:0]   rsp_data;
  logic         rsp_exec;
  logic [3:0]   flags_nzcv;

  // Lets the bench load arbitrary NZCV values, including combinations a real ALU cannot produce.
  logic         ovr_en = 1'b0;
  logic [3:0]   ovr_flags = 4'b0000;
  logic [11:0]  alu_bundle;

  int checks = 0;
  int failures = 0;

  alu_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_cond(req_cond), .req_setf(req_setf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z),
    .alu_co(alu_co), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_exec(rsp_exec),
    .flags_nzcv(flags_nzcv)
  );

  always #5 clk = ~clk;

  // Returns {result[7:0], N, Z, C, V}; subtraction carry means "no borrow".
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = 9'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b};          r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1;  r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: begin s = {1'b0, b} + {1'b0, ~a} + 9'd1;  r = s[7:0]; c = s[8]; v = (b[7] != a[7]) && (r[7] != b[7]); end
      3'b011: r = a & ~b;
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return {r, r[7], (r == 8'd0), c, v};
  endfunction

  // Condition table written from the ARM definitions (not copied from the design).
  function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return cc[0] ? ~base : base;
  endfunction

  assign alu_bundle = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_out = alu_bundle[11:4];
  assign {alu_n, alu_z, alu_co, alu_ovf} = ovr_en ? ovr_flags : alu_bundle[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one request and samples the response 2 edges after accept.
  // With rsp_ready=1 it also takes the final edge back to IDLE.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] cc, input logic sf,
                       output logic [7:0] d, output logic e);
    @(negedge clk);
    check("idle_rdy", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cond = cc; req_setf = sf;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lat1_vld", rsp_valid, 0);
    @(posedge clk); #1;
    check("lat2_vld", rsp_valid, 1);
    d = rsp_data;
    e = rsp_exec;
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic        e;
    logic [3:0]  fref;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;
    logic [3:0]  rcc;
    logic        rsf;
    logic [11:0] rb_out;
    logic        pexp;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b0; req_a = 8'h0; req_b = 8'h0;
    req_cond = 4'b0; req_setf = 1'b0; rsp_ready = 1'b1;
    #3;
    check("rst_vld", rsp_valid, 0);
    check("rst_flags", flags_nzcv, 0);
    check("rst_ctrl", alu_ctrl, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", req_ready, 1);

    // 7F + 01 -> 80, N=1 V=1
    do_op(3'b000, 8'h7F, 8'h01, 4'b1110, 1'b1, d, e);
    check("add_data", d, 8'h80);
    check("add_exec", e, 1);
    check("add_flags", flags_nzcv, 4'b1001);

    // Reset in the middle of EXEC
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_a = 8'hAA; req_b = 8'h55; req_cond = 4'b1110; req_setf = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_alu_a", alu_a, 8'hAA);
    #1 rst_n = 1'b0;
    #1;
    check("mr_alu_a", alu_a, 0);
    check("mr_alu_b", alu_b, 0);
    check("mr_ctrl", alu_ctrl, 0);
    check("mr_vld", rsp_valid, 0);
    check("mr_data", rsp_data, 0);
    check("mr_exec", rsp_exec, 0);
    check("mr_flags", flags_nzcv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_rdy", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_no_rsp", rsp_valid, 0);
    end

    // Zero result sets Z and C; then NE fails, EQ passes
    do_op(3'b001, 8'h05, 8'h05, 4'b1110, 1'b1, d, e);
    check("sub_data", d, 8'h00);
    check("sub_exec", e, 1);
    check("sub_flags", flags_nzcv, 4'b0110);
    do_op(3'b000, 8'h01, 8'h02, 4'b0001, 1'b1, d, e);
    check("ne_exec", e, 0);
    check("ne_data", d, 8'h00);
    check("ne_flags", flags_nzcv, 4'b0110);
    do_op(3'b000, 8'h01, 8'h02, 4'b0000, 1'b0, d, e);
    check("eq_exec", e, 1);
    check("eq_data", d, 8'h03);
    check("eq_flags", flags_nzcv, 4'b0110);

    // Backpressure: F0 & 3C = 30, response held for 5 cycles
    rsp_ready = 1'b0;
    do_op(3'b100, 8'hF0, 8'h3C, 4'b1110, 1'b0, d, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        req_valid = 1'b1; req_op = 3'b000; req_a = 8'h11; req_b = 8'h22; req_cond = 4'b1110; req_setf = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      check("bp_vld", rsp_valid, 1);
      check("bp_data", rsp_data, 8'h30);
      check("bp_exec", rsp_exec, 1);
      check("bp_rdy", req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vld", rsp_valid, 0);
    check("bp_rel_rdy", req_ready, 1);
    check("bp_no_acc", alu_a, 8'hF0);
    check("bp_flags", flags_nzcv, 4'b0110);

    // Condition sweep over all NZCV values
    for (int f = 0; f < 16; f++) begin
      ovr_en = 1'b1; ovr_flags = f[3:0];
      do_op(3'b000, 8'h00, 8'h00, 4'b1110, 1'b1, d, e);
      ovr_en = 1'b0;
      check("sw_preload", flags_nzcv, f[3:0]);
      for (int c = 0; c < 16; c++) begin
        do_op(3'b101, 8'h0C, 8'h30, c[3:0], 1'b0, d, e);
        pexp = cond_ref(c[3:0], f[3:0]);
        check("sw_exec", e, pexp);
        check("sw_data", d, pexp ? 8'h3C : 8'h00);
      end
    end

    // Random sequence against a reference model
    fref = flags_nzcv;
    for (int k = 0; k < 200; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rcc = 4'($urandom_range(0, 15));
      rsf = 1'($urandom_range(0, 1));
      do_op(rop, ra, rb, rcc, rsf, d, e);
      pexp = cond_ref(rcc, fref);
      rb_out = alu_fn(rop, ra, rb);
      if (pexp && rsf) fref = rb_out[3:0];
      check("rnd_exec", e, pexp);
      check("rnd_data", d, pexp ? rb_out[11:4] : 8'h00);
      check("rnd_flags", flags_nzcv, fref);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
